wallace_product_accumulator: RTL

//  Sequential consumer of the registered 16-bit product from the 8-bit Wallace tree multiplier top.

---
 rtl/wallace_product_accumulator_if.sv | 48 ++++
 rtl/wallace_product_accumulator.sv | 128 ++++++++++++
 2 files changed

// File: rtl/wallace_product_accumulator_if.sv
// ----------------------------------------------------------------------------
// wallace_product_accumulator_if
//   Bundles the product stream, the frame-sum stream and the status flags of
//   the Wallace product accumulator.
//
//   master : the side that produces products and consumes sums
//   slave  : the accumulator itself
//
//   Handshake rule for both streams: a transfer happens on a rising clock edge
//   where valid and ready are both high. The sender holds data stable while
//   valid is high and not yet accepted. prod_ready depends on accumulator
//   state only, never combinationally on prod_valid.
//
//   Signals
//     prod_in    [PROD_W]  unsigned product from the multiplier
//     prod_valid           prod_in is valid this cycle
//     prod_ready           accumulator accepts prod_in this cycle
//     clear                synchronous frame abort/flush
//     sum_out    [ACC_W]   frame sum, stable while sum_valid=1
//     sum_valid            sum_out is valid
//     sum_ready            consumer accepts sum_out
//     overflow             sticky per frame: a carry left ACC_W
//     busy                 frame in progress or waiting in DONE
// ----------------------------------------------------------------------------
interface wallace_product_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24
);
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic              clear;
    logic [ACC_W-1:0]  sum_out;
    logic              sum_valid;
    logic              sum_ready;
    logic              overflow;
    logic              busy;

    modport master (
        output prod_in, prod_valid, clear, sum_ready,
        input  prod_ready, sum_out, sum_valid, overflow, busy
    );

    modport slave (
        input  prod_in, prod_valid, clear, sum_ready,
        output prod_ready, sum_out, sum_valid, overflow, busy
    );
endinterface

// File: rtl/wallace_product_accumulator.sv
// ----------------------------------------------------------------------------
// wallace_product_accumulator
//   Sums a frame of N_TERMS unsigned multiplier products into an ACC_W-bit
//   accumulator and presents the frame sum on a valid/ready port. Any carry
//   out of ACC_W during the frame sets a sticky overflow flag for that frame.
//
//   Ports
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     bus      slave modport of wallace_product_accumulator_if (the interface
//              instance must use the same PROD_W/ACC_W as this module)
//     state_o  out  current FSM state (0=IDLE, 1=ACCUM, 2=DONE) for debug
//
//   FSM
//     IDLE  : ready for the first product; an accept loads acc and cnt=1
//     ACCUM : each accept adds into acc; the N_TERMS-th accept goes to DONE
//     DONE  : sum_valid=1, sum/overflow frozen until the consumer accepts
//     clear overrides everything except reset and returns to IDLE empty.
// ----------------------------------------------------------------------------
module wallace_product_accumulator #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    wallace_product_accumulator_if.slave  bus,
    output logic [1:0]                    state_o
);
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             prod_ready_w;
    logic             accept_w;
    logic             sum_take_w;
    logic [SUM_W-1:0] add_w;

    // Reset forces ready low even though the state already reads IDLE.
    assign prod_ready_w = rst_n && (state_q != S_DONE);
    assign accept_w     = bus.prod_valid && prod_ready_w;
    assign sum_take_w   = (state_q == S_DONE) && bus.sum_ready;

    // One extra bit keeps the carry out of ACC_W for the overflow flag.
    assign add_w = {1'b0, acc_q} + SUM_W'(bus.prod_in);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (bus.clear) begin
            // Abort: any product presented this cycle is dropped.
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_w) begin
                        acc_d   = ACC_W'(bus.prod_in);
                        cnt_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = (N_TERMS == 1) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept_w) begin
                        acc_d = add_w[ACC_W-1:0];
                        ovf_d = ovf_q | add_w[ACC_W];
                        cnt_d = cnt_q + CNT_W'(1);
                        if ((cnt_q + CNT_W'(1)) == N_LAST) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (sum_take_w) begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.prod_ready = prod_ready_w;
    assign bus.sum_valid  = (state_q == S_DONE);
    assign bus.sum_out    = acc_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign state_o        = state_q;
endmodule
